jk_bank_ctrl: RTL
=================

JK_BANK_CTRL -- requirements
Module: jk_bank_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, number of JK flip-flop bits in the controlled bank; requester count fixed at 2.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  bit i = requester i presents a command.
REQ-005 req_ready  output  2  bit i = command of requester i accepted at this edge.
REQ-006 req_op  input  2*WIDTH... no: 4 (2 per requester, bits [2i+1:2i])  JK code {j,k}: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-007 req_mask  input  2*WIDTH  bits [WIDTH*i+WIDTH-1:WIDTH*i] = bank bits affected by requester i.
REQ-008 req_cnt  input  8 (4 per requester)  repeat count, bits [4i+3:4i]; 0 treated as 1.
REQ-009 q  output  WIDTH  current bank state.
REQ-010 busy  output  1  high when state is not IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 done_id  output  1  requester index of completed command; valid while done=1.

Function
REQ-013 Bank bit n SHALL behave as a JK flip-flop: under {j,k} 00 hold, 01 clear, 10 set, 11 invert, each at a rising edge.
REQ-014 Only masked bits SHALL receive the latched op; unmasked bits SHALL receive 00 (hold).
REQ-015 FSM states SHALL be IDLE, APPLY, REPORT.
REQ-016 IDLE: req_ready SHALL be combinational, at most one bit set, and only for the arbitration winner; both bits 0 when no req_valid.
REQ-017 Arbitration SHALL be round-robin: single valid requester wins; when both are valid, the requester not granted last wins.
REQ-018 On the accept edge, op, mask, cnt (0 -> 1) and winner id SHALL be latched, remaining := cnt, last-grant pointer := winner, state -> APPLY.
REQ-019 APPLY: every edge SHALL apply the latched op to the bank and decrement remaining; the edge where remaining = 1 SHALL move state -> REPORT.
REQ-020 Accept at edge t0 with count N SHALL update q at edges t1..tN; done=1 and done_id valid during the cycle tN..tN+1; IDLE from tN+1.
REQ-021 REPORT SHALL last exactly one cycle and then return to IDLE; the next accept is possible no earlier than edge tN+2.
REQ-022 req_ready SHALL be 0 in APPLY and REPORT; a requester holding req_valid meanwhile SHALL be kept waiting with its command unconsumed.
REQ-023 req_op, req_mask, req_cnt changes after acceptance SHALL NOT affect the running command.
REQ-024 Op 00 SHALL still take N APPLY cycles and a done pulse, with q unchanged.
REQ-025 busy SHALL be 1 in APPLY and REPORT, 0 in IDLE.

Reset
REQ-026 While rst_n=0: state IDLE, q=0, busy=0, done=0, done_id=0, req_ready=0, remaining=0, last-grant pointer set so requester 0 wins the first tie.
REQ-027 rst_n assertion mid-APPLY or mid-REPORT SHALL abort the command immediately, producing no done pulse, and q SHALL be 0.
REQ-028 After rst_n deassertion, the first accept SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-029 Reset, then requester 0: op=10, mask=0101, cnt=1 -> q=0101 after 1 APPLY edge; done=1, done_id=0 the next cycle.
REQ-030 q=0101, requester 1: op=11, mask=1111, cnt=3 -> q sequence 1010, 0101, 1010; one done pulse, done_id=1, 3 busy APPLY cycles plus 1 REPORT cycle.
REQ-031 Both valid after reset, held continuously -> grants in order 0,1,0,1; req_ready never has two bits set.
REQ-032 q=1111, op=01, mask=0011, cnt=0 -> q=1100 after exactly 1 APPLY edge; bits 3:2 unchanged.
REQ-033 rst_n pulsed low during the 2nd APPLY cycle of a cnt=4 toggle -> q=0, busy=0, no done; a new request is accepted after release.
REQ-034 Op 00, cnt=2, mask=1111, q=0110 -> q stays 0110; done asserted 3 cycles after accept edge (2 APPLY + REPORT).

Source files
------------

// File: rtl/jk_bank_ctrl.sv
// Two-requester controller for a bank of JK flip-flops: a round-robin arbiter hands one
// command at a time to a small FSM, which applies the {j,k} op to the masked bits 1..15 times.
module jk_bank_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [3:0]         req_op,
   input  logic [2*WIDTH-1:0] req_mask,
   input  logic [7:0]         req_cnt,
   output logic [WIDTH-1:0]   q,
   output logic               busy,
   output logic               done,
   output logic               done_id
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      REPORT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [1:0]       op_q, op_d;
   logic [3:0]       rem_q, rem_d;
   logic             id_q, id_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             done_id_q, done_id_d;

   logic             win_valid;
   logic             win_id;
   logic [1:0]       win_op;
   logic [WIDTH-1:0] win_mask;
   logic [3:0]       win_cnt;
   logic [WIDTH-1:0] j_bits, k_bits, bank_next;

   // On a tie the requester that was not granted last wins.
   always_comb begin
      win_valid = 1'b0;
      win_id    = 1'b0;
      if (req_valid == 2'b11) begin
         win_valid = 1'b1;
         win_id    = ~last_q;
      end else if (req_valid[0]) begin
         win_valid = 1'b1;
         win_id    = 1'b0;
      end else if (req_valid[1]) begin
         win_valid = 1'b1;
         win_id    = 1'b1;
      end
   end

   assign win_op   = win_id ? req_op[3:2] : req_op[1:0];
   assign win_mask = win_id ? req_mask[2*WIDTH-1:WIDTH] : req_mask[WIDTH-1:0];
   assign win_cnt  = win_id ? req_cnt[7:4] : req_cnt[3:0];

   assign req_ready = (rst_n && (state_q == IDLE) && win_valid) ?
                      (win_id ? 2'b10 : 2'b01) : 2'b00;

   // Unmasked bits see j=k=0 and hold; masked bits follow Q+ = J&~Q | ~K&Q.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_jk
         assign j_bits[gi]    = mask_q[gi] & op_q[1];
         assign k_bits[gi]    = mask_q[gi] & op_q[0];
         assign bank_next[gi] = (j_bits[gi] & ~q_q[gi]) | (~k_bits[gi] & q_q[gi]);
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      mask_d  = mask_q;
      op_d    = op_q;
      rem_d   = rem_q;
      id_d    = id_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               op_d    = win_op;
               mask_d  = win_mask;
               rem_d   = (win_cnt == 4'd0) ? 4'd1 : win_cnt;
               id_d    = win_id;
               last_d  = win_id;
               state_d = APPLY;
            end
         end
         APPLY: begin
            q_d   = bank_next;
            rem_d = rem_q - 4'd1;
            if (rem_q == 4'd1) begin
               state_d = REPORT;
            end
         end
         REPORT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d    = (state_d != IDLE);
      done_d    = (state_d == REPORT);
      done_id_d = done_d ? id_q : done_id_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         q_q       <= '0;
         mask_q    <= '0;
         op_q      <= 2'b00;
         rem_q     <= 4'd0;
         id_q      <= 1'b0;
         last_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         q_q       <= q_d;
         mask_q    <= mask_d;
         op_q      <= op_d;
         rem_q     <= rem_d;
         id_q      <= id_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
      end
   end

   assign q       = q_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign done_id = done_id_q;

endmodule
